// File: rtl/neopixel_multi.sv
// Multi-channel WS2812 driver: Avalon-MM register/pixel buffer and one shared
// bit-timing engine that streams every channel in lockstep.
module neopixel_multi #(
  parameter int NUM_CHANNELS = 4,
  parameter int PIXELS       = 16,
  parameter int ADDR_W       = 8,
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int TBIT         = 63,
  parameter int TRESET       = 2500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_W-1:0]       address,
  input  logic                    write,
  input  logic [31:0]             writedata,
  input  logic                    read,
  output logic [31:0]             readdata,
  output logic                    waitrequest,
  output logic [NUM_CHANNELS-1:0] one_wire,
  output logic                    busy
);

  localparam int DEPTH = NUM_CHANNELS * PIXELS;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int CMAX  = (TBIT > TRESET) ? TBIT : TRESET;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [1:0] {IDLE, LOAD, BIT, GAP} state_t;

  logic [23:0]             mem [DEPTH];
  logic [23:0]             load_word [NUM_CHANNELS];
  logic [23:0]             sr_reg [NUM_CHANNELS];
  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [4:0]              bit_idx_reg;
  logic [PIX_W-1:0]        pix_idx_reg;
  logic [8:0]              len_reg, len_shadow_reg;
  logic                    auto_reg, pending_reg, busy_reg;
  logic [NUM_CHANNELS-1:0] ow_reg;
  logic [31:0]             rd_reg;

  logic [ADDR_W-1:0] off;
  logic [IDX_W-1:0]  pix_addr;
  logic              in_pix, ctrl_wr, len_wr, start_wr, auto_eff;
  logic [8:0]        len_clamped;
  logic              unused_bits;

  assign off         = address - ADDR_W'(4);
  assign pix_addr    = off[IDX_W-1:0];
  assign in_pix      = (address >= ADDR_W'(4)) && (off < ADDR_W'(DEPTH));
  assign ctrl_wr     = write && (address == '0);
  assign len_wr      = write && (address == ADDR_W'(1));
  assign start_wr    = ctrl_wr && writedata[0];
  // A CTRL write landing on the last gap cycle must steer the gap exit.
  assign auto_eff    = ctrl_wr ? writedata[1] : auto_reg;
  assign len_clamped = (writedata[8:0] == 9'd0)        ? 9'd1 :
                       (writedata[8:0] > 9'(PIXELS))  ? 9'(PIXELS) : writedata[8:0];
  assign unused_bits = &{1'b0, writedata[31:24], off};

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    assign load_word[gi] = mem[IDX_W'(gi * PIXELS) + IDX_W'(pix_idx_reg)];
  end

  function automatic logic cell_high(input logic b, input logic [CNT_W-1:0] k);
    return k < (b ? CNT_W'(T1H) : CNT_W'(T0H));
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (write && in_pix) begin
      mem[pix_addr] <= writedata[23:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_reg <= '0;
    end else if (read) begin
      if (address == '0)             rd_reg <= {29'd0, pending_reg, auto_reg, busy_reg};
      else if (address == ADDR_W'(1)) rd_reg <= {23'd0, len_reg};
      else if (in_pix)               rd_reg <= {8'd0, mem[pix_addr]};
      else                           rd_reg <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      bit_idx_reg    <= '0;
      pix_idx_reg    <= '0;
      len_reg        <= 9'(PIXELS);
      len_shadow_reg <= 9'(PIXELS);
      auto_reg       <= 1'b0;
      pending_reg    <= 1'b0;
      busy_reg       <= 1'b0;
      ow_reg         <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) sr_reg[c] <= '0;
    end else begin
      if (ctrl_wr) auto_reg <= writedata[1];
      if (len_wr)  len_reg  <= len_clamped;
      if (start_wr && state_reg != IDLE) pending_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          ow_reg <= '0;
          if (start_wr) begin
            state_reg      <= LOAD;
            busy_reg       <= 1'b1;
            pix_idx_reg    <= '0;
            len_shadow_reg <= len_reg;
          end
        end
        LOAD: begin
          for (int c = 0; c < NUM_CHANNELS; c++) begin
            sr_reg[c] <= load_word[c];
            ow_reg[c] <= cell_high(load_word[c][23], '0);
          end
          bit_idx_reg <= 5'd23;
          cnt_reg     <= '0;
          state_reg   <= BIT;
        end
        BIT: begin
          if (cnt_reg == CNT_W'(TBIT - 1)) begin
            cnt_reg <= '0;
            if (bit_idx_reg != 5'd0) begin
              bit_idx_reg <= bit_idx_reg - 5'd1;
              for (int c = 0; c < NUM_CHANNELS; c++) begin
                sr_reg[c] <= {sr_reg[c][22:0], 1'b0};
                ow_reg[c] <= cell_high(sr_reg[c][22], '0);
              end
            end else if (9'(pix_idx_reg) < len_shadow_reg - 9'd1) begin
              pix_idx_reg <= pix_idx_reg + PIX_W'(1);
              ow_reg      <= '0;
              state_reg   <= LOAD;
            end else begin
              ow_reg    <= '0;
              state_reg <= GAP;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
            for (int c = 0; c < NUM_CHANNELS; c++)
              ow_reg[c] <= cell_high(sr_reg[c][23], cnt_reg + CNT_W'(1));
          end
        end
        GAP: begin
          ow_reg <= '0;
          if (cnt_reg == CNT_W'(TRESET - 1)) begin
            cnt_reg <= '0;
            if (pending_reg || start_wr || auto_eff) begin
              pending_reg    <= 1'b0;
              pix_idx_reg    <= '0;
              len_shadow_reg <= len_reg;
              state_reg      <= LOAD;
            end else begin
              busy_reg  <= 1'b0;
              state_reg <= IDLE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign readdata    = rd_reg;
  assign waitrequest = 1'b0;
  assign one_wire    = ow_reg;
  assign busy        = busy_reg;

endmodule
